// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared definitions for the instruction fetch stage:
//   - fetch_state_t : fetch FSM state encoding
//   - DEFAULT_RESET_PC : default PC loaded on reset
//   - OPCODE_* / FUNC_* : instruction field positions, shared with the
//     control unit decode macros
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        OUT,
        DRAIN,
        HALT
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned FUNC_W     = FUNC_MSB - FUNC_LSB + 1;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the fetch stage's two handshakes:
//   - instruction memory: imem_req/imem_addr/imem_gnt, imem_rvalid/imem_rdata
//   - decode: inst_valid/inst_ready with inst, opcode, func, inst_pc, pc_plus4
// Modports:
//   master : the fetch unit (drives requests and the decoded instruction)
//   slave  : the environment (memory responder and decode stage)
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;

    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   func;
    logic [ADDR_W-1:0]   inst_pc;
    logic [ADDR_W-1:0]   pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, opcode, func, inst_pc, pc_plus4,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, opcode, func, inst_pc, pc_plus4,
        output inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Single-outstanding-request instruction fetch stage feeding decode.
// Holds the PC, fetches one word at a time, presents it to decode under
// valid/ready, and handles redirects and halt by discarding stale responses.
// Ports:
//   clk, rst_b        : clock, synchronous active-low reset
//   bus (master)      : imem req/gnt + rvalid/rdata, decode valid/ready + inst
//   redirect_valid    : load redirect_target into the PC (ignored when halted)
//   redirect_target   : new PC; bits [1:0] are dropped, align_err flags them
//   halt              : stop fetching, takes priority over redirect
//   halted            : fetch has stopped
//   align_err         : sticky, a redirect target was misaligned
//   fetch_count       : instructions accepted by decode (wraps)
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst_b,
    inst_fetch_unit_if.master   bus,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    input  logic                halt,
    output logic                halted,
    output logic                align_err,
    output logic [31:0]         fetch_count
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halt_pend_q, halt_pend_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [31:0]       count_q, count_d;
    logic              align_q, align_d;

    logic              outstanding;
    logic              halting;
    logic              squash;

    // A pending halt keeps squashing every DRAIN cycle so that a redirect
    // arriving while draining cannot move the PC or cancel the halt.
    assign halting = halt || halt_pend_q;
    assign squash  = (state_q != HALT) && (halting || redirect_valid);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halt_pend_d = halt_pend_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        pc_plus4_d  = pc_plus4_q;
        count_d     = count_q;
        align_d     = align_q;
        outstanding = 1'b0;

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                outstanding = bus.imem_gnt;
                if (bus.imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                outstanding = !bus.imem_rvalid;
                if (bus.imem_rvalid && !squash) begin
                    inst_d     = bus.imem_rdata;
                    inst_pc_d  = pc_q;
                    pc_plus4_d = pc_q + ADDR_W'(4);
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (bus.inst_ready && !squash) begin
                    count_d = count_q + 32'd1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                outstanding = !bus.imem_rvalid;
                if (bus.imem_rvalid) state_d = FETCH;
            end
            HALT: ;
            default: state_d = IDLE;
        endcase

        // Squash overrides the normal transitions: the in-flight response,
        // if any, is drained before fetching or halting.
        if (squash) begin
            if (halting) begin
                if (outstanding) begin
                    halt_pend_d = 1'b1;
                    state_d     = DRAIN;
                end else begin
                    state_d = HALT;
                end
            end else begin
                pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
                if (redirect_target[1:0] != 2'b00) align_d = 1'b1;
                state_d = outstanding ? DRAIN : FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            halt_pend_q <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            pc_plus4_q  <= '0;
            count_q     <= '0;
            align_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            halt_pend_q <= halt_pend_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            pc_plus4_q  <= pc_plus4_d;
            count_q     <= count_d;
            align_q     <= align_d;
        end
    end

    assign bus.imem_req   = (state_q == FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = (state_q == OUT);
    assign bus.inst       = inst_q;
    assign bus.opcode     = inst_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.func       = inst_q[FUNC_MSB:FUNC_LSB];
    assign bus.inst_pc    = inst_pc_q;
    assign bus.pc_plus4   = pc_plus4_q;

    assign halted      = (state_q == HALT);
    assign align_err   = align_q;
    assign fetch_count = count_q;

endmodule
